// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite responder terminating into a bank of 32-bit registers
//
// Purpose: accepts AXI4-Lite writes (with byte strobes) and reads into
// NUM_REGS 32-bit registers, and exports the register contents flat with a
// one-cycle update strobe per register. Independent write and read FSMs.
//
// Ports:
//   clk, rst_n                  single clock, synchronous active-low reset
//   s_axi_aw*                   write address channel (awaddr, awvalid, awready)
//   s_axi_w*                    write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*                    write response channel (bresp, bvalid, bready)
//   s_axi_ar*                   read address channel (araddr, arvalid, arready)
//   s_axi_r*                    read data channel (rdata, rresp, rvalid, rready)
//   reg_out                     register k at bits [32k+31:32k]
//   reg_wr_pulse                one-cycle strobe, bit k, when register k updates
//
// Build option: AXI_SLV_ADDR_ERR_EN - when defined, out-of-range accesses
// respond SLVERR; otherwise they respond OKAY (writes dropped, reads return 0).

module axi_lite_slave_regs #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SLV_ADDR_ERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  // NUM_REGS is a power of two, so "word address < NUM_REGS" is the same
  // as every address bit above the index field being zero.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:2+IDX_W] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  // Byte-lane offset bits play no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], aw_addr_q[1:0]};

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit happens on the edge where the later of AW/W handshakes; the
  // earlier half comes from the capture registers.
  logic                  commit;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [31:0]           commit_data;
  logic [3:0]            commit_strb;

  always_comb begin
    commit      = 1'b0;
    commit_addr = s_axi_awaddr;
    commit_data = s_axi_wdata;
    commit_strb = s_axi_wstrb;
    case (w_state)
      W_IDLE:   commit = aw_hs && w_hs;
      W_HAVE_A: begin
        commit      = w_hs;
        commit_addr = aw_addr_q;
      end
      W_HAVE_D: begin
        commit      = aw_hs;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
      end
      default:  commit = 1'b0;
    endcase
  end

  logic             commit_ok;
  logic [IDX_W-1:0] commit_idx;
  assign commit_ok  = addr_in_range(commit_addr);
  assign commit_idx = addr_index(commit_addr);

  // Write channel FSM; readies are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else if (commit) begin
      w_state       <= W_RESP;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b1;
      s_axi_bresp   <= commit_ok ? RESP_OKAY : RESP_OOR;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q     <= s_axi_awaddr;
            w_state       <= W_HAVE_A;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
          end else if (w_hs) begin
            w_data_q      <= s_axi_wdata;
            w_strb_q      <= s_axi_wstrb;
            w_state       <= W_HAVE_D;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
          end else begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_HAVE_A: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
        end
        W_HAVE_D: begin
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b0;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state       <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register bank; out-of-range commits never touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && commit_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (commit_strb[b]) begin
            regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
          end
        end
        reg_wr_pulse[commit_idx] <= |commit_strb;
      end
    end
  end

  // Read channel FSM. rdata samples regs before any same-edge write lands,
  // so a colliding read returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            if (addr_in_range(s_axi_araddr)) begin
              s_axi_rdata <= regs[addr_index(s_axi_araddr)];
              s_axi_rresp <= RESP_OKAY;
            end else begin
              s_axi_rdata <= '0;
              s_axi_rresp <= RESP_OOR;
            end
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            r_state       <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - scoreboard bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [16*32-1:0] reg_out;
  logic [15:0]  reg_wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

`ifdef AXI_SLV_ADDR_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.NUM_REGS(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_val(input int k);
    return reg_out[k*32 +: 32];
  endfunction

  // Response monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", bresp, exp_b.pop_front());
    end
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] resp, input logic [15:0] pulse, input string tag);
    int t = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && t < 20) begin step(); t++; end
    if (t == 20) check({tag, "_ready_timeout"}, 0, 1);
    exp_b.push_back(resp);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_pulse"}, reg_wr_pulse, pulse);
    t = 0;
    while (!bvalid && t < 20) begin step(); t++; end
    if (t == 20) check({tag, "_bvalid_timeout"}, 0, 1);
    step();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                    input string tag);
    int t = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!arready && t < 20) begin step(); t++; end
    if (t == 20) check({tag, "_arready_timeout"}, 0, 1);
    exp_r.push_back({resp, data});
    step();
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin step(); t++; end
    if (t == 20) check({tag, "_rvalid_timeout"}, 0, 1);
    step();
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_regs_zero", reg_out == '0, 1);
    rst_n = 1'b1;
    step();
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // AW+W same cycle to 0x08
    awaddr = 32'h08; wdata = 32'h0000_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    exp_b.push_back(2'b00);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_reg2", reg_val(2), 32'h0000_1111);
    check("t1_pulse", reg_wr_pulse, 16'h0004);
    check("t1_bvalid", bvalid, 1);
    check("t1_readies_low", {awready, wready}, 2'b00);
    step();
    check("t1_pulse_off", reg_wr_pulse, 0);
    check("t1_bvalid_hold", bvalid, 1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("t1_bvalid_clear", bvalid, 0);
    check("t1_readies_back", {awready, wready}, 2'b11);

    // W first, AW three cycles later
    wdata = 32'hAABB_CCDD; wstrb = 4'h5; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("t2_have_d_readies", {awready, wready}, 2'b10);
    check("t2_no_pulse", reg_wr_pulse, 0);
    step();
    step();
    check("t2_reg3_unchanged", reg_val(3), 0);
    check("t2_no_bvalid", bvalid, 0);
    step();
    awaddr = 32'h0C; awvalid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    awvalid = 1'b0;
    check("t2_reg3", reg_val(3), 32'h00BB_00DD);
    check("t2_pulse", reg_wr_pulse, 16'h0008);
    bready = 1'b1;
    step();
    bready = 1'b0;

    // Read 0x08 with rready held low
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    exp_r.push_back({2'b00, 32'h0000_1111});
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid_hold", rvalid, 1);
      check("t3_rdata_stable", rdata, 32'h0000_1111);
      check("t3_arready_low", arready, 0);
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("t3_rvalid_clear", rvalid, 0);
    check("t3_arready_back", arready, 1);

    // Same-cycle commit and AR to 0x10
    check("t4_idle_readies", {awready, wready, arready}, 3'b111);
    awaddr = 32'h10; wdata = 32'h1234_5678; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h0});
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t4_reg4", reg_val(4), 32'h1234_5678);
    step();
    bready = 1'b0; rready = 1'b0;
    rd(32'h10, 32'h1234_5678, 2'b00, "t4_followup");

    // Out-of-range 0x40, plus in-range edge of the bank
    wr(32'h40, 32'hDEAD_BEEF, 4'hF, OOR_RESP, 16'h0, "oor_wr");
    check("oor_reg0_untouched", reg_val(0), 0);
    rd(32'h40, 32'h0, OOR_RESP, "oor_rd");
    wr(32'h3C, 32'hCAFE_F00D, 4'hF, 2'b00, 16'h8000, "top_wr");
    rd(32'h3F, 32'hCAFE_F00D, 2'b00, "top_rd_lowbits");

    // wstrb = 0: OKAY, nothing written
    wr(32'h14, 32'hFFFF_FFFF, 4'h0, 2'b00, 16'h0, "strb0");
    check("strb0_reg5", reg_val(5), 0);

    // Reset while in W_HAVE_A
    awaddr = 32'h14; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("t6_have_a_readies", {awready, wready}, 2'b01);
    rst_n = 1'b0;
    step();
    step();
    check("t6_in_rst_outputs", {awready, wready, arready, bvalid, rvalid}, 0);
    rst_n = 1'b1;
    step();
    check("t6_readies", {awready, wready, arready}, 3'b111);
    check("t6_valids", {bvalid, rvalid, bresp, rresp}, 0);
    check("t6_rdata", rdata, 0);
    check("t6_regs_zero", reg_out == '0, 1);
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    step();
    check("t6_no_stale_commit", bvalid, 0);
    check("t6_reg5", reg_val(5), 0);

    check("b_queue_drained", exp_b.size(), 0);
    check("r_queue_drained", exp_r.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
